// File: rtl/jdiv_pkg.sv
// ============================================================================
// Module      : jdiv_pkg
// Description : Shared types and default sizing for the sequential divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jdiv_pkg;

    localparam int N_DEFAULT     = 4;
    localparam int W2_DEFAULT    = 2 * N_DEFAULT;
    localparam int CNT_W_DEFAULT = $clog2(W2_DEFAULT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/jdiv_step.sv
// ============================================================================
// Module      : jdiv_step
// Description : One combinational restoring shift/trial-subtract iteration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jdiv_step #(
    parameter int N = 4
) (
    input  logic [N:0]   rem_in,
    input  logic         bit_in,
    input  logic [N-1:0] dmag,
    output logic [N:0]   rem_out,
    output logic         q_bit
);

    logic [N:0]   w_shifted;
    logic [N+1:0] w_trial;

    // A set top bit means the shifted value exceeds any divisor magnitude.
    always_comb begin
        w_shifted = {rem_in[N-1:0], bit_in};
        w_trial   = {1'b0, w_shifted} - {2'b00, dmag};
        q_bit     = rem_in[N] | ~w_trial[N+1];
        rem_out   = q_bit ? w_trial[N:0] : w_shifted;
    end

endmodule

`default_nettype wire

// File: rtl/jseq_divider.sv
// ============================================================================
// Module      : jseq_divider
// Description : Sequential signed restoring divider, 2N / N bits, one bit/clk.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jseq_divider
    import jdiv_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             ready,
    output logic             done,
    output logic [2*N-1:0]   quotient,
    output logic [N-1:0]     remainder,
    output logic             dbz,
    output logic             ovf
);

    localparam int W     = 2 * N;
    localparam int CNT_W = $clog2(W);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [W-1:0]       r_qreg;
    logic [N:0]         r_prem;
    logic [N-1:0]       r_dmag;
    logic               r_qneg;
    logic               r_rneg;
    logic               r_dbz;

    logic               w_accept;
    logic [W-1:0]       w_dd_mag;
    logic [N-1:0]       w_dv_mag;
    logic [N:0]         w_prem_nxt;
    logic               w_qbit;

    assign ready    = (r_state == S_IDLE) || (r_state == S_DONE);
    assign done     = (r_state == S_DONE);
    assign w_accept = start && ready;
    assign w_dd_mag = dividend[W-1] ? -dividend : dividend;
    assign w_dv_mag = divisor[N-1]  ? -divisor  : divisor;

    jdiv_step #(.N(N)) u_step (
        .rem_in  (r_prem),
        .bit_in  (r_qreg[W-1]),
        .dmag    (r_dmag),
        .rem_out (w_prem_nxt),
        .q_bit   (w_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CALC;
            S_CALC:  if (r_cnt == '0) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = start ? S_CALC : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_qreg    <= '0;
            r_prem    <= '0;
            r_dmag    <= '0;
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
            r_dbz     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else if (w_accept) begin
            r_cnt  <= CNT_W'(W - 1);
            r_qreg <= w_dd_mag;
            r_prem <= '0;
            r_dmag <= w_dv_mag;
            r_qneg <= dividend[W-1] ^ divisor[N-1];
            r_rneg <= dividend[W-1];
            r_dbz  <= (divisor == '0);
        end else if (r_state == S_CALC) begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_qreg <= {r_qreg[W-2:0], w_qbit};
            r_prem <= w_prem_nxt;
        end else if (r_state == S_FIX) begin
            // Only -2^(2N-1) / -1 yields a positive magnitude of 2^(2N-1).
            if (r_dbz) begin
                quotient  <= '1;
                remainder <= '0;
                dbz       <= 1'b1;
                ovf       <= 1'b0;
            end else if (!r_qneg && r_qreg == {1'b1, {(W-1){1'b0}}}) begin
                quotient  <= {1'b0, {(W-1){1'b1}}};
                remainder <= '0;
                dbz       <= 1'b0;
                ovf       <= 1'b1;
            end else begin
                quotient  <= r_qneg ? -r_qreg : r_qreg;
                remainder <= r_rneg ? -r_prem[N-1:0] : r_prem[N-1:0];
                dbz       <= 1'b0;
                ovf       <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
